// File: rtl/dmem_access_ctrl_pkg.sv
// Shared Y86 definitions for the memory-stage access controller:
// icode and stat constants and the transaction FSM state type.
package y86_pkg;

  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Request/response channel between the M-stage initiator (master)
// and the multi-cycle data memory (slave).
interface dmem_access_ctrl_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;
  logic        mem_rsp_err;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );
endinterface

// File: rtl/dmem_access_ctrl_decode.sv
// Combinational M-stage decode: which icodes touch data memory, the
// direction, and which pipeline value supplies address and write data.
module mem_op_decode
  import y86_pkg::*;
(
  input  logic [3:0]  icode_i,
  input  logic [63:0] valA_i,
  input  logic [63:0] valE_i,
  input  logic [63:0] valP_i,
  output logic        is_mem_o,
  output logic        we_o,
  output logic [63:0] addr_o,
  output logic [63:0] wdata_o
);

  // icode to memory-operation table
  always_comb begin
    is_mem_o = 1'b0;
    we_o     = 1'b0;
    addr_o   = 64'd0;
    wdata_o  = 64'd0;
    case (icode_i)
      IRMMOVQ, IPUSHQ: begin
        is_mem_o = 1'b1;
        we_o     = 1'b1;
        addr_o   = valE_i;
        wdata_o  = valA_i;
      end
      IMRMOVQ: begin
        is_mem_o = 1'b1;
        addr_o   = valE_i;
      end
      ICALL: begin
        is_mem_o = 1'b1;
        we_o     = 1'b1;
        addr_o   = valE_i;
        wdata_o  = valP_i;
      end
      // ret and popq read from the old stack pointer held in valA
      IRET, IPOPQ: begin
        is_mem_o = 1'b1;
        addr_o   = valA_i;
      end
      default: begin
        is_mem_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Memory-stage initiator: issues one request per M-stage memory op,
// stalls the pipeline until the response (or timeout) and reports valM.
module dmem_access_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned DMEM_DEPTH = 1024,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               m_valid,
  input  logic [3:0]         m_icode,
  input  logic [63:0]        m_valA,
  input  logic [63:0]        m_valE,
  input  logic [63:0]        m_valP,
  output logic               m_stall,
  output logic [63:0]        m_valM,
  output logic               m_dmem_error,
  output logic               m_done,
  dmem_access_ctrl_if.master mem
);

  localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
  localparam logic [63:0]   MAX_ADDR = 64'(DMEM_DEPTH - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

  mem_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        req_valid_q, req_valid_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] valm_q, valm_d;
  logic        err_q, err_d;

  logic        dec_is_mem, dec_we;
  logic [63:0] dec_addr, dec_wdata;
  logic        op_ok, op_bad;

  mem_op_decode u_decode (
    .icode_i  (m_icode),
    .valA_i   (m_valA),
    .valE_i   (m_valE),
    .valP_i   (m_valP),
    .is_mem_o (dec_is_mem),
    .we_o     (dec_we),
    .addr_o   (dec_addr),
    .wdata_o  (dec_wdata)
  );

  assign op_bad = m_valid & dec_is_mem & (dec_addr > MAX_ADDR);
  assign op_ok  = m_valid & dec_is_mem & ~(dec_addr > MAX_ADDR);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_valid_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 64'd0;
      wdata_q     <= 64'd0;
      valm_q      <= 64'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_valid_q <= req_valid_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      valm_q      <= valm_d;
      err_q       <= err_d;
    end
  end

  // Next-state and next-register logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_valid_d = req_valid_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    valm_d      = valm_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (op_ok) begin
          state_d     = ST_REQ;
          req_valid_d = 1'b1;
          we_d        = dec_we;
          addr_d      = dec_addr;
          wdata_d     = dec_wdata;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (req_valid_q && mem.mem_req_ready) begin
          state_d     = ST_WAIT;
          req_valid_d = 1'b0;
          cnt_d       = '0;
        end else begin
          state_d = ST_REQ;
        end
      end
      // A response arriving on the last counted cycle still beats the timeout
      ST_WAIT: begin
        if (mem.mem_rsp_valid) begin
          state_d = ST_DONE;
          valm_d  = we_q ? 64'd0 : mem.mem_rsp_rdata;
          err_d   = mem.mem_rsp_err;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_DONE;
          valm_d  = 64'd0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pipeline-facing outputs
  always_comb begin
    m_stall      = 1'b0;
    m_done       = 1'b0;
    m_valM       = 64'd0;
    m_dmem_error = 1'b0;
    if (reset) begin
      m_stall = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (op_bad) begin
            m_done       = 1'b1;
            m_dmem_error = 1'b1;
          end else begin
            m_stall = op_ok;
          end
        end
        ST_REQ, ST_WAIT: begin
          m_stall = 1'b1;
        end
        ST_DONE: begin
          m_done       = 1'b1;
          m_valM       = valm_q;
          m_dmem_error = err_q;
        end
        default: begin
          m_stall = 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_req_valid = req_valid_q;
  assign mem.mem_req_we    = we_q;
  assign mem.mem_req_addr  = addr_q;
  assign mem.mem_req_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: expected requests and results are
// queued at stimulus time and popped when the DUT accepts / completes.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid;
  logic [3:0]  m_icode;
  logic [63:0] m_valA, m_valE, m_valP;
  logic        m_stall, m_dmem_error, m_done;
  logic [63:0] m_valM;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct { logic we; logic [63:0] addr; logic [63:0] wdata; } req_t;
  typedef struct { logic [63:0] valm; logic err; } res_t;
  req_t req_q[$];
  res_t res_q[$];

  dmem_access_ctrl_if mem_if ();

  dmem_access_ctrl #(.DMEM_DEPTH(1024), .TIMEOUT(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .m_valid      (m_valid),
    .m_icode      (m_icode),
    .m_valA       (m_valA),
    .m_valE       (m_valE),
    .m_valP       (m_valP),
    .m_stall      (m_stall),
    .m_valM       (m_valM),
    .m_dmem_error (m_dmem_error),
    .m_done       (m_done),
    .mem          (mem_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive_quiet();
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_rsp_valid = 1'b0;
    mem_if.mem_rsp_rdata = 64'd0;
    mem_if.mem_rsp_err   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_valid"}, 64'(mem_if.mem_req_valid), 64'd0);
    check({tag, "_req_we"},    64'(mem_if.mem_req_we), 64'd0);
    check({tag, "_req_addr"},  mem_if.mem_req_addr, 64'd0);
    check({tag, "_req_wdata"}, mem_if.mem_req_wdata, 64'd0);
    check({tag, "_stall"},     64'(m_stall), 64'd0);
    check({tag, "_valM"},      m_valM, 64'd0);
    check({tag, "_err"},       64'(m_dmem_error), 64'd0);
    check({tag, "_done"},      64'(m_done), 64'd0);
  endtask

  // rsp_dly: WAIT cycle (1 = cycle after acceptance) carrying the response, <=0 = never
  task automatic run_op(input string name, input logic [3:0] ic,
                        input logic [63:0] va, input logic [63:0] ve, input logic [63:0] vp,
                        input int rdy_dly, input int rsp_dly,
                        input logic [63:0] rdata, input logic rerr,
                        input logic exp_issue, input logic exp_we,
                        input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
                        input logic [63:0] exp_valm, input logic exp_err, input int exp_stall);
    int   stall_cnt = 0;
    int   req_cyc   = 0;
    int   wait_cyc  = 0;
    bit   accepted  = 1'b0;
    bit   done      = 1'b0;
    res_t r;
    if (exp_issue) req_q.push_back('{exp_we, exp_addr, exp_wdata});
    res_q.push_back('{exp_valm, exp_err});
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      @(negedge clk);
      m_valid = 1'b1; m_icode = ic; m_valA = va; m_valE = ve; m_valP = vp;
      drive_quiet();
      if (accepted) begin
        wait_cyc++;
        if (rsp_dly > 0 && wait_cyc == rsp_dly) begin
          mem_if.mem_rsp_valid = 1'b1;
          mem_if.mem_rsp_rdata = rdata;
          mem_if.mem_rsp_err   = rerr;
        end
      end
      if (mem_if.mem_req_valid) begin
        if (req_cyc >= rdy_dly) mem_if.mem_req_ready = 1'b1;
        req_cyc++;
        if (req_q.size() == 0) begin
          check({name, "_unexpected_req"}, 64'd1, 64'd0);
        end else begin
          check({name, "_req_we"}, 64'(mem_if.mem_req_we), 64'(req_q[0].we));
          check({name, "_req_addr"}, mem_if.mem_req_addr, req_q[0].addr);
          if (req_q[0].we) check({name, "_req_wdata"}, mem_if.mem_req_wdata, req_q[0].wdata);
          if (mem_if.mem_req_ready) begin
            void'(req_q.pop_front());
            accepted = 1'b1;
          end
        end
      end
      #1;
      if (m_stall) stall_cnt++;
      if (m_done) begin
        done = 1'b1;
        r = res_q.pop_front();
        check({name, "_valM"}, m_valM, r.valm);
        check({name, "_err"}, 64'(m_dmem_error), 64'(r.err));
        check({name, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_stall));
      end
    end
    if (!done) begin
      check({name, "_done_timeout"}, 64'd0, 64'd1);
      res_q.delete();
    end
    check({name, "_req_pending"}, 64'(req_q.size()), 64'd0);
    req_q.delete();
    // Next instruction is a bubble: done must not repeat, no second request
    @(negedge clk);
    m_valid = 1'b0;
    drive_quiet();
    #1;
    check({name, "_done_pulse"}, 64'(m_done), 64'd0);
    check({name, "_no_reissue"}, 64'(mem_if.mem_req_valid), 64'd0);
    check({name, "_idle_stall"}, 64'(m_stall), 64'd0);
  endtask

  task automatic idle_cycles(input string name, input logic v, input logic [3:0] ic,
                             input logic stray, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      m_valid = v; m_icode = ic; m_valA = 64'd7; m_valE = 64'd5; m_valP = 64'd9;
      drive_quiet();
      mem_if.mem_rsp_valid = stray;
      mem_if.mem_rsp_rdata = 64'hDEAD;
      #1;
      check({name, "_stall"}, 64'(m_stall), 64'd0);
      check({name, "_done"}, 64'(m_done), 64'd0);
      check({name, "_req_valid"}, 64'(mem_if.mem_req_valid), 64'd0);
      check({name, "_valM"}, m_valM, 64'd0);
    end
  endtask

  initial begin
    bit acc = 1'b0;
    reset = 1'b1;
    m_valid = 1'b0; m_icode = 4'h0; m_valA = 64'd0; m_valE = 64'd0; m_valP = 64'd0;
    drive_quiet();
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    run_op("rmmovq", 4'h4, 64'h2A, 64'd5, 64'd0, 0, 1, 64'd0, 1'b0,
           1'b1, 1'b1, 64'd5, 64'h2A, 64'd0, 1'b0, 3);
    run_op("mrmovq_rdy4", 4'h5, 64'd0, 64'd4, 64'd0, 4, 1, 64'h2, 1'b0,
           1'b1, 1'b0, 64'd4, 64'd0, 64'h2, 1'b0, 7);
    run_op("popq", 4'hB, 64'd7, 64'd15, 64'd0, 0, 1, 64'h1234, 1'b0,
           1'b1, 1'b0, 64'd7, 64'd0, 64'h1234, 1'b0, 3);
    run_op("ret", 4'h9, 64'd3, 64'd99, 64'd0, 0, 2, 64'h55, 1'b0,
           1'b1, 1'b0, 64'd3, 64'd0, 64'h55, 1'b0, 4);
    run_op("call", 4'h8, 64'h77, 64'd9, 64'h40, 0, 1, 64'hFFFF, 1'b0,
           1'b1, 1'b1, 64'd9, 64'h40, 64'd0, 1'b0, 3);
    run_op("pushq_top", 4'hA, 64'hBEEF, 64'd1023, 64'd0, 1, 3, 64'd0, 1'b0,
           1'b1, 1'b1, 64'd1023, 64'hBEEF, 64'd0, 1'b0, 6);
    run_op("addr_err_1024", 4'h4, 64'h1, 64'd1024, 64'd0, 0, 1, 64'd0, 1'b0,
           1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b1, 0);
    run_op("addr_err_pop", 4'hB, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd0, 0, 1, 64'd0, 1'b0,
           1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b1, 0);
    run_op("timeout", 4'h5, 64'd0, 64'd12, 64'd0, 0, -1, 64'd0, 1'b0,
           1'b1, 1'b0, 64'd12, 64'd0, 64'd0, 1'b1, 18);
    run_op("rsp_at_limit", 4'h5, 64'd0, 64'd13, 64'd0, 0, 16, 64'h77, 1'b0,
           1'b1, 1'b0, 64'd13, 64'd0, 64'h77, 1'b0, 18);
    run_op("wr_rsp_err", 4'h4, 64'h11, 64'd20, 64'd0, 0, 1, 64'h99, 1'b1,
           1'b1, 1'b1, 64'd20, 64'h11, 64'd0, 1'b1, 3);
    run_op("rd_rsp_err", 4'h5, 64'd0, 64'd21, 64'd0, 0, 1, 64'h66, 1'b1,
           1'b1, 1'b0, 64'd21, 64'd0, 64'h66, 1'b1, 3);

    idle_cycles("nop_icode6", 1'b1, 4'h6, 1'b0, 3);
    idle_cycles("bubble", 1'b0, 4'h5, 1'b0, 3);
    idle_cycles("stray_rsp", 1'b0, 4'h0, 1'b1, 3);

    // Reset while a read is outstanding, then a late response
    for (int cyc = 0; cyc < 10 && !acc; cyc++) begin
      @(negedge clk);
      m_valid = 1'b1; m_icode = 4'h5; m_valA = 64'd0; m_valE = 64'd30; m_valP = 64'd0;
      drive_quiet();
      if (mem_if.mem_req_valid) begin
        mem_if.mem_req_ready = 1'b1;
        acc = 1'b1;
      end
    end
    check("rst_wait_accepted", 64'(acc), 64'd1);
    repeat (2) begin
      @(negedge clk);
      drive_quiet();
      #1;
      check("rst_wait_stall", 64'(m_stall), 64'd1);
    end
    @(negedge clk);
    reset = 1'b1;
    m_valid = 1'b0;
    drive_quiet();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("after_reset");
    @(negedge clk);
    mem_if.mem_rsp_valid = 1'b1;
    mem_if.mem_rsp_rdata = 64'hBAD;
    #1;
    check("late_rsp_done", 64'(m_done), 64'd0);
    check("late_rsp_stall", 64'(m_stall), 64'd0);
    @(negedge clk);
    drive_quiet();
    #1;
    check("late_rsp_done_next", 64'(m_done), 64'd0);
    check("late_rsp_valM_next", m_valM, 64'd0);

    run_op("mrmovq_after_rst", 4'h5, 64'd0, 64'd31, 64'd0, 0, 1, 64'hCAFE, 1'b0,
           1'b1, 1'b0, 64'd31, 64'd0, 64'hCAFE, 1'b0, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Memory-stage initiator for the PIPE datapath.
- Decodes the M-stage instruction, then issues one read or write transaction to a multi-cycle data memory over a valid/ready request channel and a valid response channel.
- Stalls the pipeline until the transaction completes, then returns valM and the data-memory error flag to the W-stage logic.
- It is the requesting end; the data memory array is the responder.

Parameters:
- DMEM_DEPTH, 1024, number of 64-bit words in data memory; valid word addresses are 0..DMEM_DEPTH-1.
- TIMEOUT, 16, maximum cycles to wait for a response after request acceptance before flagging an error.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- m_valid  in  1  M stage holds a real (non-bubble) instruction.
- m_icode  in  4  M-stage icode.
- m_valA  in  64  M-stage valA.
- m_valE  in  64  M-stage valE.
- m_valP  in  64  M-stage valP.
- m_stall  out  1  hold F/D/E/M pipeline registers this cycle.
- m_valM  out  64  read data; valid while m_done=1.
- m_dmem_error  out  1  address or memory error; valid while m_done=1.
- m_done  out  1  one-cycle pulse: memory op for the current M instruction is complete.
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  responder accepts the request.
- mem_req_we  out  1  1 = write, 0 = read.
- mem_req_addr  out  64  word address.
- mem_req_wdata  out  64  write data.
- mem_rsp_valid  in  1  response valid; also used as the write acknowledgement.
- mem_rsp_rdata  in  64  read data.
- mem_rsp_err  in  1  responder-side error.

Behaviour:
- Op decode (icode to kind / address / data):
  - 4 rmmovq: write, address valE, data valA.
  - 5 mrmovq: read, address valE.
  - 8 call: write, address valE, data valP.
  - 9 ret: read, address valA.
  - A pushq: write, address valE, data valA.
  - B popq: read, address valA.
  - Any other icode, or m_valid=0: no-op.
- Address error: selected address > DMEM_DEPTH-1.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - No-op: stay in IDLE; m_stall=0, m_done=0.
  - Memory op with address error: no request issued; m_done=1, m_dmem_error=1, m_valM=0 this cycle; m_stall=0; stay in IDLE.
  - Memory op, address OK: m_stall=1; register we/addr/wdata; go to REQ.
- REQ:
  - mem_req_valid=1; we/addr/wdata held stable until accepted.
  - On mem_req_valid && mem_req_ready: go to WAIT and clear the timeout counter.
  - m_stall=1.
- WAIT:
  - m_stall=1; counter increments each cycle.
  - On mem_rsp_valid: latch rdata (reads only; writes latch 0) and rsp_err; go to DONE.
  - If the counter reaches TIMEOUT with no response: latch error=1, valM=0; go to DONE.
  - If mem_rsp_valid and timeout occur in the same cycle, the response wins.
- DONE:
  - m_stall=0, m_done=1; m_valM and m_dmem_error driven from the latches.
  - Return to IDLE.
  - The pipeline advances on this edge, so IDLE sees the next instruction.
- Minimum latency: instruction in M at cycle N, ready=1 at N+1, rsp at N+2, done at N+3. m_stall is high for cycles N..N+2.
- Response rules:
  - A response is never expected in the same cycle as acceptance.
  - mem_rsp_valid outside WAIT is ignored (stray response).
- Exactly one request is issued per M-stage instruction. There is no re-issue after DONE even if m_icode is unchanged, because the pipeline has advanced.
- Reset, including mid-transaction: state=IDLE and all outputs 0 (mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, m_stall, m_valM, m_dmem_error, m_done). The counter clears and an outstanding response is subsequently ignored.
- m_stall is combinational from state and decode. All mem_req_* outputs are registered.

Decomposition:
- y86_pkg holds:
  - icode constants: IRMMOVQ=4'h4, IMRMOVQ=4'h5, ICALL=4'h8, IRET=4'h9, IPUSHQ=4'hA, IPOPQ=4'hB.
  - stat codes: SAOK=1, SHLT=2, SADR=3, SINS=4.
  - the FSM state enum.
- Sub-module mem_op_decode (combinational) takes icode, valA, valE, valP and returns is_mem, we, addr, wdata.

Test Plan:
- rmmovq: icode=4, valA=0x2A, valE=5, ready=1, rsp at +1 → one request (we=1, addr=5, wdata=0x2A); m_stall high 3 cycles; m_done at N+3 with m_dmem_error=0.
- mrmovq: icode=5, valE=4, rsp_rdata=0x2 → m_valM=0x2 with m_done; ready held low 4 cycles → request stable and stall extended by 4.
- popq / ret: icode=B, valA=7, valE=15 → addr=7, we=0. call: icode=8, valP=0x40, valE=9 → wdata=0x40, addr=9.
- Errors:
  - valE=1024 with DMEM_DEPTH=1024 → no mem_req_valid; m_done and m_dmem_error in the same cycle, no stall.
  - No response for 16 cycles → m_dmem_error=1.
  - rsp_err=1 → m_dmem_error=1.
- Non-memory op (icode=6) or m_valid=0 → no request, m_stall=0. A stray mem_rsp_valid in IDLE → no output change.
- Assert reset during WAIT → next cycle all outputs 0. A late mem_rsp_valid is ignored, and a following mrmovq completes normally.
